// File: rtl/seven_segment_scan_controller_if.sv
// Bundle between the scan controller and its user: digit codes in, decoder/display drive out.
// No valid/ready here: en is a level-sensitive run request, frame_done is a one-cycle pulse.
interface seven_segment_scan_controller_if #(
    parameter int NDIGITS = 4
);
    logic                       en;
    logic [4*NDIGITS-1:0]       bcd_in;
    logic [NDIGITS-1:0]         dp_in;
    logic                       lz_suppress;
    logic [3:0]                 bcd_out;
    logic                       dp_out;
    logic [NDIGITS-1:0]         digit_sel;
    logic [$clog2(NDIGITS)-1:0] digit_idx;
    logic                       frame_done;
    logic [1:0]                 dbgState;

    modport master (
        output en, bcd_in, dp_in, lz_suppress,
        input  bcd_out, dp_out, digit_sel, digit_idx, frame_done, dbgState
    );

    modport slave (
        input  en, bcd_in, dp_in, lz_suppress,
        output bcd_out, dp_out, digit_sel, digit_idx, frame_done, dbgState
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Multiplexes NDIGITS BCD digits onto one shared decoder with a dark gap before each digit,
// a once-per-frame input snapshot, leading-zero suppression and blanking of invalid codes.
module seven_segment_scan_controller #(
    parameter int NDIGITS          = 4,
    parameter int REFRESH_TICKS    = 100000,
    parameter int BLANK_TICKS      = 1000,
    parameter int DIGIT_ACTIVE_LOW = 0
) (
    input logic clk,
    input logic rst,
    seven_segment_scan_controller_if.slave bus
);
    localparam int IW   = $clog2(NDIGITS);
    localparam int MAXT = (REFRESH_TICKS > BLANK_TICKS) ? REFRESH_TICKS : BLANK_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [IW-1:0]      LAST_IDX = IW'(NDIGITS - 1);
    localparam logic [NDIGITS-1:0] SEL_OFF  = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NDIGITS-1:0] SEL_ONE  = NDIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } stateT;

    stateT                state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [4*NDIGITS-1:0] bcdSnap;
    logic [NDIGITS-1:0]   dpSnap;
    logic                 lzSnap;
    logic                 showBlank;
    logic [3:0]           bcdOutR;
    logic                 dpOutR;
    logic [NDIGITS-1:0]   digitSelR;
    logic                 frameDoneR;

    // A digit is dark if its code is invalid, or it is a zero with only zero/dark digits above it.
    function automatic logic [NDIGITS-1:0] blankMask(
        input logic [4*NDIGITS-1:0] bcd,
        input logic [NDIGITS-1:0]   dp,
        input logic                 lz
    );
        logic [NDIGITS-1:0] m;
        logic [3:0]         code;
        logic               higherDark;
        m          = '0;
        higherDark = 1'b1;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            code       = bcd[4*k +: 4];
            m[k]       = (code > 4'd9) ||
                         (lz && (k != 0) && (code == 4'd0) && !dp[k] && higherDark);
            higherDark = higherDark && ((code == 4'd0) || m[k]);
        end
        return m;
    endfunction

    // Values for the digit about to enter BLANK; a fresh frame reads the live inputs.
    logic                 loadNew;
    logic [IW-1:0]        nextIdx;
    logic [4*NDIGITS-1:0] srcBcd;
    logic [NDIGITS-1:0]   srcDp;
    logic                 srcLz;
    logic [NDIGITS-1:0]   srcMask;
    logic [3:0]           srcCode;
    logic [3:0]           loadBcd;
    logic                 loadDp;
    logic                 loadBlank;

    always_comb begin
        loadNew   = (state == IDLE) || (idx == LAST_IDX);
        nextIdx   = loadNew ? '0 : idx + 1'b1;
        srcBcd    = loadNew ? bus.bcd_in : bcdSnap;
        srcDp     = loadNew ? bus.dp_in : dpSnap;
        srcLz     = loadNew ? bus.lz_suppress : lzSnap;
        srcMask   = blankMask(srcBcd, srcDp, srcLz);
        srcCode   = srcBcd[4*int'(nextIdx) +: 4];
        loadBcd   = (srcCode > 4'd9) ? 4'd0 : srcCode;
        loadDp    = srcDp[nextIdx];
        loadBlank = srcMask[nextIdx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            bcdSnap    <= '0;
            dpSnap     <= '0;
            lzSnap     <= 1'b0;
            showBlank  <= 1'b0;
            bcdOutR    <= 4'd0;
            dpOutR     <= 1'b0;
            digitSelR  <= SEL_OFF;
            frameDoneR <= 1'b0;
        end else if (!bus.en) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            showBlank  <= 1'b0;
            bcdOutR    <= 4'd0;
            dpOutR     <= 1'b0;
            digitSelR  <= SEL_OFF;
            frameDoneR <= 1'b0;
        end else begin
            frameDoneR <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= BLANK;
                    cnt       <= '0;
                    idx       <= nextIdx;
                    bcdSnap   <= bus.bcd_in;
                    dpSnap    <= bus.dp_in;
                    lzSnap    <= bus.lz_suppress;
                    bcdOutR   <= loadBcd;
                    dpOutR    <= loadDp;
                    showBlank <= loadBlank;
                    digitSelR <= SEL_OFF;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_TICKS - 1)) begin
                        state      <= SHOW;
                        cnt        <= '0;
                        digitSelR  <= showBlank ? SEL_OFF : (SEL_OFF ^ (SEL_ONE << idx));
                        frameDoneR <= (idx == LAST_IDX) && (REFRESH_TICKS == 1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == CW'(REFRESH_TICKS - 1)) begin
                        state     <= BLANK;
                        cnt       <= '0;
                        idx       <= nextIdx;
                        bcdOutR   <= loadBcd;
                        dpOutR    <= loadDp;
                        showBlank <= loadBlank;
                        digitSelR <= SEL_OFF;
                        if (loadNew) begin
                            bcdSnap <= bus.bcd_in;
                            dpSnap  <= bus.dp_in;
                            lzSnap  <= bus.lz_suppress;
                        end
                    end else begin
                        cnt        <= cnt + 1'b1;
                        // Registered pulse must be set one cycle ahead to land on the last SHOW cycle.
                        frameDoneR <= (idx == LAST_IDX) && (cnt == CW'(REFRESH_TICKS - 2));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bcd_out    = bcdOutR;
    assign bus.dp_out     = dpOutR;
    assign bus.digit_sel  = digitSelR;
    assign bus.digit_idx  = idx;
    assign bus.frame_done = frameDoneR;
    assign bus.dbgState   = state;
endmodule

// File: doc/seven_segment_scan_controller.md
Name: seven_segment_scan_controller

Overview:
- Time-multiplexes NDIGITS BCD digits onto one shared SevenSegmentDecoder instance and a multi-digit common-cathode display module.
- Selects one digit at a time and drives the shared BCD code and decimal point to the decoder.
- Drives one-hot digit enables, inserting a blanking gap between digits to suppress ghosting.
- Adds frame-coherent input snapshotting, leading-zero suppression and blanking of invalid codes.

Parameters:
- NDIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_TICKS, 100000, clock cycles each digit is enabled (SHOW phase, >=1).
- BLANK_TICKS, 1000, clock cycles all digits are off before each digit (BLANK phase, >=1).
- DIGIT_ACTIVE_LOW, 0, 1 inverts digit_sel polarity for external PNP/NPN drivers.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; 0 = display dark
- bcd_in  input  4*NDIGITS  digit codes; digit k = bcd_in[4k+3:4k], digit 0 is least significant
- dp_in  input  NDIGITS  per-digit decimal point request
- lz_suppress  input  1  1 = blank leading zeros
- bcd_out  output  4  code to shared decoder BCD input
- dp_out  output  1  decimal point to shared segment bus
- digit_sel  output  NDIGITS  one-hot digit enable (polarity per DIGIT_ACTIVE_LOW)
- digit_idx  output  $clog2(NDIGITS)  index of the digit currently sequenced
- frame_done  output  1  one-cycle pulse at the end of the last digit's SHOW phase

Behaviour:
- Reset (asynchronous, immediate) and IDLE output values:
  - state = IDLE; bcd_out = 0; dp_out = 0; digit_idx = 0; frame_done = 0.
  - digit_sel all inactive: all 0, or all 1 if DIGIT_ACTIVE_LOW.
  - Internal snapshot register cleared to 0; tick counter cleared to 0.
- FSM states: IDLE, BLANK, SHOW. All outputs are registered.
- IDLE:
  - Outputs held at reset values.
  - en=1 moves to BLANK, digit_idx=0, on the next edge.
  - Snapshot of bcd_in, dp_in and lz_suppress taken on that same edge.
- BLANK:
  - Lasts exactly BLANK_TICKS cycles; digit_sel inactive throughout.
  - bcd_out and dp_out are loaded from snapshot[digit_idx] on the entry edge, so the code is stable BLANK_TICKS cycles before the enable.
  - Then moves to SHOW.
- SHOW:
  - Lasts exactly REFRESH_TICKS cycles; digit_sel has bit digit_idx active, unless the digit is blanked.
  - On exit, digit_idx increments and the FSM moves to BLANK.
  - Wrap-around: from NDIGITS-1 the index returns to 0, frame_done pulses on the final SHOW cycle, and a new snapshot is taken on the wrap edge.
  - Inputs are therefore sampled once per frame; mid-frame changes to bcd_in are invisible until the next frame (no tearing).
- Frame length = NDIGITS*(BLANK_TICKS+REFRESH_TICKS) cycles.
- Digit blanking (digit_sel stays inactive for the whole SHOW phase; timing is unchanged):
  - Invalid code: snapshot code > 9. bcd_out is forced to 0 so the decoder never sees an undecoded value. dp_out still follows dp.
  - Leading zero: lz_suppress=1, code == 0, digit_idx != 0, and every higher-index digit is also zero or blanked. Digit 0 is never suppressed by this rule.
  - A leading-zero-suppressed digit whose dp is 1 is NOT blanked; it is shown as "0." to keep the decimal point visible.
- en deasserted in any state: next edge returns to IDLE with reset output values; the counter and index are cleared. Re-enable restarts at digit 0 with a fresh snapshot.
- Tick counter width = $clog2(max(REFRESH_TICKS, BLANK_TICKS)). Terminal count is compared at TICKS-1, with no off-by-one: phase lengths are exact.
- digit_sel is never multi-hot, in any cycle or state.

Test Plan:
Bench parameters for all scenarios: NDIGITS=4, REFRESH_TICKS=8, BLANK_TICKS=2, DIGIT_ACTIVE_LOW=0.
- Basic scan: rst pulse, then en=1, bcd_in=16'h4321, lz_suppress=0.
  -> digit_sel sequence 0001, 0010, 0100, 1000; each active for 8 cycles after 2 dark cycles.
  -> bcd_out = 1, 2, 3, 4, changing at BLANK entry.
  -> frame_done pulses every 40 cycles.
- Snapshot coherence: change bcd_in from 16'h4321 to 16'h8765 while digit_idx=1.
  -> Digits 2 and 3 of the current frame still show 3 and 4.
  -> The next frame shows 5, 6, 7, 8.
- Leading zeros: bcd_in=16'h0050, lz_suppress=1.
  -> digit_sel stays 0 for digits 3 and 2; digits 1 and 0 enabled (0 shown for digit 0).
  -> With dp_in=4'b0100: digit 2 enabled with bcd_out=0, dp_out=1.
- Invalid code: bcd_in=16'h1A23.
  -> Digit 2 dark with bcd_out=0; the other digits are shown normally.
  -> Frame length is still 40 cycles.
- Disable/reset mid-operation:
  - Drop en during SHOW of digit 2 -> next cycle digit_sel=0, bcd_out=0, digit_idx=0. Re-enable -> scan restarts at digit 0.
  - Assert rst asynchronously between clock edges -> outputs clear immediately, with no clock edge required.
- One-hot check: assertion across all scenarios that digit_sel has at most one active bit in every cycle.
